arm_multicycle_ctrl: RTL

//  Multicycle sequencer for the ARM-subset datapath: decodes cond/op/funct/rd from the latched

---
 rtl/arm_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle control sequencer for the ARM-subset datapath.
// It decodes the latched instruction, holds NZCV, and handshakes with the shared memory port.
//
// state     | meaning
// FETCH     | request instruction at PC, latch IR and advance PC on ready
// DECODE    | condition check against NZCV, illegal-encoding trap
// EXECUTE   | data-processing ALU op, optional flag update
// ALUWB     | write ALU result to rd (or PC when rd is R15)
// MEMADR    | compute load/store address from base +/- imm12
// MEMRD     | load request at ALU address, held until ready
// MEMWB     | write read data to rd (or PC)
// MEMWR     | store request at ALU address, held until ready
// BRANCH    | PC <= PC+8 + imm24<<2
module arm_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cond,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic [3:0]       rd,
    input  logic [3:0]       alu_flags,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [2:0]       alu_control,
    output logic [1:0]       imm_src,
    output logic [1:0]       reg_src,
    output logic             shift_flag,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);
    localparam bit TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q;
    logic              retire;
    logic              cond_pass, wait_expired, in_wait, is_cmp;
    logic              cmd_legal, cmd_arith;

    logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, pc_src_c;
    logic       reg_write_c, mem_to_reg_c, alu_src_c, shift_flag_c, illegal_c, bus_err_c;
    logic [2:0] alu_control_c;
    logic [1:0] imm_src_c, reg_src_c;

    assign is_cmp       = (funct[4:1] == 4'b1010);
    assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_LIMIT);
    assign in_wait      = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = nzcv_q[2];
            4'b0001: cond_pass = !nzcv_q[2];
            4'b0010: cond_pass = nzcv_q[1];
            4'b0011: cond_pass = !nzcv_q[1];
            4'b0100: cond_pass = nzcv_q[3];
            4'b0101: cond_pass = !nzcv_q[3];
            4'b0110: cond_pass = nzcv_q[0];
            4'b0111: cond_pass = !nzcv_q[0];
            4'b1000: cond_pass = nzcv_q[1] && !nzcv_q[2];
            4'b1001: cond_pass = !nzcv_q[1] || nzcv_q[2];
            4'b1010: cond_pass = (nzcv_q[3] == nzcv_q[0]);
            4'b1011: cond_pass = (nzcv_q[3] != nzcv_q[0]);
            4'b1100: cond_pass = !nzcv_q[2] && (nzcv_q[3] == nzcv_q[0]);
            4'b1101: cond_pass = nzcv_q[2] || (nzcv_q[3] != nzcv_q[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        nzcv_d        = nzcv_q;
        retire        = 1'b0;
        cmd_legal     = 1'b1;
        cmd_arith     = 1'b0;
        mem_req_c     = 1'b0;
        mem_write_c   = 1'b0;
        adr_src_c     = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        pc_src_c      = 1'b0;
        reg_write_c   = 1'b0;
        mem_to_reg_c  = 1'b0;
        alu_src_c     = 1'b0;
        alu_control_c = 3'b000;
        imm_src_c     = 2'b00;
        reg_src_c     = 2'b00;
        shift_flag_c  = 1'b0;
        illegal_c     = 1'b0;
        bus_err_c     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    mem_req_c  = 1'b1;
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (wait_expired) begin
                    bus_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    mem_req_c = 1'b1;
                end
            end
            S_DECODE: begin
                if (cond == 4'b1111 || op == 2'b11) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (!cond_pass) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        2'b00:   state_d = S_EXECUTE;
                        2'b01:   state_d = S_MEMADR;
                        default: state_d = S_BRANCH;
                    endcase
                end
            end
            S_EXECUTE: begin
                alu_src_c = funct[5];
                case (funct[4:1])
                    4'b0100:          cmd_arith = 1'b1;
                    4'b0010, 4'b1010: begin alu_control_c = 3'b001; cmd_arith = 1'b1; end
                    4'b0000:          alu_control_c = 3'b010;
                    4'b1100:          alu_control_c = 3'b011;
                    4'b1101:          shift_flag_c = 1'b1;
                    default:          cmd_legal = 1'b0;
                endcase
                if (!cmd_legal) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    // Logical ops leave C and V untouched.
                    if (funct[0] || is_cmp)
                        nzcv_d = cmd_arith ? alu_flags : {alu_flags[3:2], nzcv_q[1:0]};
                    if (is_cmp) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_ALUWB;
                    end
                end
            end
            S_ALUWB: begin
                if (rd == 4'd15) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 1'b1;
                end else begin
                    reg_write_c = 1'b1;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_c     = 1'b1;
                imm_src_c     = 2'b01;
                alu_control_c = funct[3] ? 3'b000 : 3'b001;
                state_d       = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready || !wait_expired) begin
                    mem_req_c = 1'b1;
                    adr_src_c = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end else begin
                    bus_err_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                if (rd == 4'd15) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 1'b1;
                end else begin
                    reg_write_c = 1'b1;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready || !wait_expired) begin
                    mem_req_c   = 1'b1;
                    mem_write_c = 1'b1;
                    adr_src_c   = 1'b1;
                    reg_src_c   = 2'b10;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    bus_err_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_BRANCH: begin
                reg_src_c  = 2'b01;
                alu_src_c  = 1'b1;
                imm_src_c  = 2'b10;
                pc_src_c   = 1'b1;
                pc_write_c = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // A timeout re-enters FETCH, so it restarts the wait count like any other entry.
    always_comb begin
        wait_d = '0;
        if (in_wait && state_d == state_q && !bus_err_c)
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            nzcv_q    <= '0;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            nzcv_q  <= nzcv_d;
            wait_q  <= wait_d;
            if (retire)
                instret_q <= instret_q + 1'b1;
        end
    end

    // Gating by reset keeps a transfer aborted by reset from leaking ir/pc/mem strobes.
    assign mem_req     = mem_req_c & ~reset;
    assign mem_write   = mem_write_c & ~reset;
    assign adr_src     = adr_src_c & ~reset;
    assign ir_write    = ir_write_c & ~reset;
    assign pc_write    = pc_write_c & ~reset;
    assign pc_src      = pc_src_c & ~reset;
    assign reg_write   = reg_write_c & ~reset;
    assign mem_to_reg  = mem_to_reg_c & ~reset;
    assign alu_src     = alu_src_c & ~reset;
    assign alu_control = reset ? 3'b000 : alu_control_c;
    assign imm_src     = reset ? 2'b00 : imm_src_c;
    assign reg_src     = reset ? 2'b00 : reg_src_c;
    assign shift_flag  = shift_flag_c & ~reset;
    assign illegal     = illegal_c & ~reset;
    assign bus_err     = bus_err_c & ~reset;
    assign instret     = reset ? '0 : instret_q;

endmodule
